// File: rtl/match_dp_pkg.sv
// match_dp_pkg: shared state encoding and default constants for match_datapath
package match_dp_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_B, OUT_LD, WAIT} state_t;
    localparam int DEF_MATCH = 5;
    localparam int DEF_HIT = 8;
    localparam int DEF_MISS = 13;
endpackage

// File: rtl/match_dp_ctrl.sv
// match_dp_ctrl: sequencing FSM issuing the load strobes for the A/B datapath
module match_dp_ctrl
    import match_dp_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    input  logic out_ready,
    input  logic a_status,
    output logic in_ready,
    output logic out_valid,
    output logic busy,
    output logic a_load,
    output logic b_load,
    output logic mux_sel,
    output logic out_load,
    output logic cnt_inc
);
    state_t state, state_nxt;
    // state register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    // next state and per-state strobes
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        a_load    = 1'b0;
        b_load    = 1'b0;
        out_load  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                a_load   = in_valid;
                if (in_valid) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                b_load    = 1'b1;
                state_nxt = OUT_LD;
            end
            OUT_LD: begin
                out_load  = 1'b1;
                cnt_inc   = a_status;
                state_nxt = WAIT;
            end
            WAIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy    = state != IDLE;
        mux_sel = a_status;
    end
endmodule

// File: rtl/match_datapath.sv
// match_datapath: A/B register datapath with match detect, handshakes and hit counter
module match_datapath
    import match_dp_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MATCH_VAL  = DEF_MATCH,
    parameter int CONST_HIT  = DEF_HIT,
    parameter int CONST_MISS = DEF_MISS,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     din_a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     dout_b,
    output logic                 a_status,
    output logic [CNT_WIDTH-1:0] hit_count,
    input  logic                 clr_count,
    output logic                 busy
);
    localparam logic [WIDTH-1:0] MATCH_W = WIDTH'(MATCH_VAL);
    localparam logic [WIDTH-1:0] HIT_W   = WIDTH'(CONST_HIT);
    localparam logic [WIDTH-1:0] MISS_W  = WIDTH'(CONST_MISS);
    logic [WIDTH-1:0] a_q, b_q;
    logic a_load, b_load, mux_sel, out_load, cnt_inc;
    assign a_status = a_q == MATCH_W;
    match_dp_ctrl u_ctrl (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .a_status (a_status),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .busy     (busy),
        .a_load   (a_load),
        .b_load   (b_load),
        .mux_sel  (mux_sel),
        .out_load (out_load),
        .cnt_inc  (cnt_inc)
    );
    // operand, result and saturating hit counter registers; clear beats increment
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            dout_b    <= '0;
            hit_count <= '0;
        end else begin
            if (a_load) a_q <= din_a;
            if (b_load) b_q <= mux_sel ? HIT_W : MISS_W;
            if (out_load) dout_b <= b_q;
            if (clr_count) hit_count <= '0;
            else if (cnt_inc && hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
        end
endmodule

// File: tb/tb_match_datapath.sv
// tb_match_datapath: directed checks plus a transaction-level model for two configurations
module tb_match_datapath;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_n     [2];
    logic       in_valid  [2];
    logic       out_ready [2];
    logic       clr       [2];
    logic [7:0] din       [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic       a_status  [2];
    logic       busy      [2];
    logic [3:0] dout0;
    logic [7:0] dout1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int nvec = 0;
    int nfail = 0;

    match_datapath u0 (
        .clock(clock), .reset_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .din_a(din[0][3:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .dout_b(dout0), .a_status(a_status[0]), .hit_count(cnt0), .clr_count(clr[0]),
        .busy(busy[0])
    );

    match_datapath #(.WIDTH(8), .MATCH_VAL('hA5), .CONST_HIT('h3C), .CONST_MISS('hC3),
                     .CNT_WIDTH(2)) u1 (
        .clock(clock), .reset_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .din_a(din[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .dout_b(dout1), .a_status(a_status[1]), .hit_count(cnt1), .clr_count(clr[1]),
        .busy(busy[1])
    );

    task automatic chk(input string n, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic int dv(input int i);
        return i != 0 ? int'(dout1) : int'(dout0);
    endfunction

    function automatic int cv(input int i);
        return i != 0 ? int'(cnt1) : int'(cnt0);
    endfunction

    // Per-instance transaction model: an accepted word produces its result two edges
    // later, the result stays offered until taken, and only then is a new word accepted.
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int MV   = g != 0 ? 'hA5 : 5;
        localparam int HV   = g != 0 ? 'h3C : 8;
        localparam int XV   = g != 0 ? 'hC3 : 13;
        localparam int MSK  = g != 0 ? 255 : 15;
        localparam int CMAX = g != 0 ? 3 : 255;
        bit infl = 1'b0;
        bit ov = 1'b0;
        int age = 0;
        int ec = 0;
        int ea = 0;
        int ed = 0;

        always @(posedge clock or negedge rst_n[g]) begin
            if (!rst_n[g]) begin
                infl = 1'b0;
                ov = 1'b0;
                age = 0;
                ec = 0;
                ea = 0;
                ed = 0;
            end else begin
                if (infl) begin
                    age++;
                    if (age == 2) begin
                        ov = 1'b1;
                        ed = (ea == MV) ? HV : XV;
                        if (ea == MV && ec < CMAX) ec++;
                    end else if (age > 2 && out_ready[g]) begin
                        ov = 1'b0;
                        infl = 1'b0;
                    end
                end else if (in_valid[g]) begin
                    infl = 1'b1;
                    age = 0;
                    ea = int'(din[g]) & MSK;
                end
                if (clr[g]) ec = 0;
            end
        end

        always @(negedge clock) begin
            chk($sformatf("m%0d_in_ready", g), int'(in_ready[g]), int'(!infl));
            chk($sformatf("m%0d_busy", g), int'(busy[g]), int'(infl));
            chk($sformatf("m%0d_out_valid", g), int'(out_valid[g]), int'(ov));
            chk($sformatf("m%0d_dout_b", g), dv(g), ed);
            chk($sformatf("m%0d_a_status", g), int'(a_status[g]), int'(ea == MV));
            chk($sformatf("m%0d_hit_count", g), cv(g), ec);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send(input int i, input int v);
        int t = 0;
        while (!in_ready[i] && t < 20) begin
            step(1);
            t++;
        end
        chk("send_ready", int'(in_ready[i]), 1);
        in_valid[i] = 1'b1;
        din[i] = 8'(v);
        step(1);
        in_valid[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b0;
            clr[i] = 1'b0;
            din[i] = 8'd0;
        end
        step(2);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        step(1);
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", int'(in_ready[i]), 1);
            chk("rst_busy", int'(busy[i]), 0);
            chk("rst_out_valid", int'(out_valid[i]), 0);
            chk("rst_dout", dv(i), 0);
            chk("rst_count", cv(i), 0);
            chk("rst_a_status", int'(a_status[i]), 0);
        end

        out_ready[0] = 1'b1;
        send(0, 5);
        chk("hit_a_status", int'(a_status[0]), 1);
        chk("hit_busy", int'(busy[0]), 1);
        chk("hit_ov_k0", int'(out_valid[0]), 0);
        step(1);
        chk("hit_ov_k1", int'(out_valid[0]), 0);
        step(1);
        chk("hit_ov_k2", int'(out_valid[0]), 1);
        chk("hit_dout", dv(0), 8);
        chk("hit_count1", cv(0), 1);
        step(1);
        chk("hit_done", int'(out_valid[0]), 0);

        send(0, 3);
        chk("miss_a_status", int'(a_status[0]), 0);
        step(2);
        chk("miss_dout", dv(0), 13);
        chk("miss_count", cv(0), 1);
        step(1);

        out_ready[0] = 1'b0;
        send(0, 5);
        step(2);
        chk("stall_dout", dv(0), 8);
        chk("stall_count", cv(0), 2);
        in_valid[0] = 1'b1;
        din[0] = 8'd3;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("stall_ov", int'(out_valid[0]), 1);
            chk("stall_hold", dv(0), 8);
            chk("stall_in_ready", int'(in_ready[0]), 0);
            chk("stall_a", int'(a_status[0]), 1);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        step(1);
        chk("stall_release", int'(out_valid[0]), 0);

        for (int k = 0; k < 260; k++) send(0, 5);
        step(3);
        chk("sat255", cv(0), 255);
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        chk("clr255", cv(0), 0);

        send(0, 5);
        step(3);
        chk("pre_rst_count", cv(0), 1);
        send(0, 5);
        #1 rst_n[0] = 1'b0;
        #1;
        chk("arst_ov", int'(out_valid[0]), 0);
        chk("arst_dout", dv(0), 0);
        chk("arst_count", cv(0), 0);
        chk("arst_in_ready", int'(in_ready[0]), 1);
        chk("arst_busy", int'(busy[0]), 0);
        #4 rst_n[0] = 1'b1;
        step(1);
        send(0, 3);
        step(2);
        chk("post_rst_ov", int'(out_valid[0]), 1);
        chk("post_rst_dout", dv(0), 13);
        chk("post_rst_count", cv(0), 0);
        step(1);

        out_ready[1] = 1'b1;
        send(1, 'hA5);
        step(2);
        chk("w8_hit", dv(1), 'h3C);
        step(1);
        send(1, 'hA4);
        step(2);
        chk("w8_miss", dv(1), 'hC3);
        step(1);
        chk("w8_count1", cv(1), 1);
        for (int k = 0; k < 5; k++) send(1, 'hA5);
        step(3);
        chk("w8_sat3", cv(1), 3);
        send(1, 'hA5);
        step(1);
        clr[1] = 1'b1;
        step(1);
        clr[1] = 1'b0;
        chk("clr_vs_inc", cv(1), 0);
        chk("clr_vs_inc_ov", int'(out_valid[1]), 1);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/match_datapath.md
Name: match_datapath

Overview:
- Parametrised successor to the team's 4-bit A/B register-transfer datapath.
- Adds an internal controller FSM, valid/ready handshakes on input and output, and programmable match and constant values.
- Adds a saturating hit counter.
- Sits between an upstream producer of operand words and a downstream consumer of result words.

Parameters:
WIDTH, 4, data width of A, B and dout_b
MATCH_VAL, 5, value of A that counts as a hit
CONST_HIT, 8, value loaded into B on a hit
CONST_MISS, 13, value loaded into B on a miss
CNT_WIDTH, 8, width of hit_count

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  din_a is valid
in_ready  output  1  block accepts din_a this cycle
din_a  input  WIDTH  operand A
out_valid  output  1  dout_b holds a result
out_ready  input  1  consumer takes the result
dout_b  output  WIDTH  result register
a_status  output  1  (A == MATCH_VAL), combinational from the A register
hit_count  output  CNT_WIDTH  number of hits, saturating
clr_count  input  1  synchronous clear of hit_count
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clock; reset is asynchronous and active-low on reset_n.
- Reset values:
  - state = IDLE; A = 0; B = 0; dout_b = 0; out_valid = 0; hit_count = 0.
  - in_ready = 1; busy = 0.
  - a_status reflects A = 0, so it is 1 only if MATCH_VAL = 0.
- State machine:
  - IDLE: in_ready = 1. If in_valid, then A <= din_a and go to LOAD_B. Otherwise hold.
  - LOAD_B: in_ready = 0. B <= CONST_HIT if a_status, else CONST_MISS. Go to OUT_LD.
  - OUT_LD: dout_b <= B; out_valid <= 1. If hit, hit_count <= hit_count + 1, saturating at all-ones. Go to WAIT.
  - WAIT: out_valid = 1 and dout_b is stable. If out_ready, then out_valid <= 0 and go to IDLE. Otherwise hold indefinitely.
- Latency:
  - Input accepted at edge k: B is valid after edge k+1, and out_valid/dout_b after edge k+2.
  - Minimum spacing between accepted inputs is 4 cycles, reached when out_ready is tied to 1.
- Register rules:
  - A changes only on an IDLE accept.
  - B changes only in LOAD_B.
  - dout_b changes only in OUT_LD and holds its last value after the handshake.
- clr_count:
  - Zeroes hit_count on the next edge.
  - Has priority over a simultaneous increment in OUT_LD; the result is 0.
- Counter: saturates at 2^CNT_WIDTH-1 and does not wrap.
- Handshakes:
  - The in_valid/din_a handshake completes only in IDLE; in_valid in any other state is ignored and not queued.
  - out_ready outside WAIT has no effect.
- Reset mid-operation: asynchronous return to the reset values from any state; no partial result is emitted.
- Width rules:
  - Constants are truncated to WIDTH bits.
  - The comparison is unsigned and full width.

Decomposition:
- Package match_dp_pkg:
  - State enum: IDLE, LOAD_B, OUT_LD, WAIT (2-bit encoding).
  - Default constants DEF_MATCH = 5, DEF_HIT = 8, DEF_MISS = 13.
- One sub-module, match_dp_ctrl:
  - Holds the FSM.
  - Produces the a_load, b_load, mux_sel, out_load and cnt_inc strobes.
  - The top level holds the A, B, dout_b and counter registers.

Test Plan:
- Reset, then din_a = 5 with in_valid for one cycle, out_ready = 1 -> out_valid rises 2 edges after the accept edge; dout_b = 8; hit_count = 1; a_status = 1.
- din_a = 3 accepted -> dout_b = 13; hit_count unchanged; a_status = 0 after the accept edge.
- Result pending with out_ready = 0 for 10 cycles -> out_valid stays 1; dout_b is stable; in_valid = 1 with din_a = 5 is ignored (in_ready = 0); A is unchanged.
- CNT_WIDTH = 2: five hits -> hit_count = 3 (saturates). Then clr_count asserted in the same cycle as an OUT_LD hit -> hit_count = 0.
- reset_n pulsed low in LOAD_B -> immediately state = IDLE, out_valid = 0, dout_b = 0, hit_count = 0; the next accept behaves as after a fresh reset.
- WIDTH = 8, MATCH_VAL = 0xA5, CONST_HIT = 0x3C, CONST_MISS = 0xC3: inputs 0xA5, 0xA4 -> outputs 0x3C, 0xC3 in order.
